// File: rtl/i2s_target_if.sv
// I2S target bundle: serial wire pins plus the parallel rx/tx sample ports.
// The master modport is the external I2S master / sample consumer side.
interface i2s_target_if #(
    parameter int DataWidth = 12
);
    logic                        sclk;
    logic                        lrck;
    logic                        sdin;
    logic                        sdout;
    logic signed [DataWidth-1:0] rxData;
    logic                        rxChannel;
    logic                        rxValid;
    logic                        frameError;
    logic signed [DataWidth-1:0] txLeft;
    logic signed [DataWidth-1:0] txRight;
    logic                        txValid;
    logic                        txTaken;

    modport master (
        output sclk, lrck, sdin, txLeft, txRight, txValid,
        input  sdout, rxData, rxChannel, rxValid, frameError, txTaken
    );

    modport slave (
        input  sclk, lrck, sdin, txLeft, txRight, txValid,
        output sdout, rxData, rxChannel, rxValid, frameError, txTaken
    );
endinterface

// File: rtl/i2s_target.sv
// I2S target endpoint: oversamples sclk/lrck/sdin on clk, deserialises stereo
// samples and serialises the pending tx pair back onto sdout.
module i2s_target #(
    parameter int DataWidth = 12
) (
    input logic        clk,
    input logic        reset,
    i2s_target_if.slave bus
);
    localparam int SerialDataWidth = 24;
    localparam int SlotWidth       = 32;
    localparam int CntW            = $clog2(SlotWidth);
    localparam int SW              = SerialDataWidth;

    typedef enum logic [1:0] {
        SYNC_S,
        DELAY_S,
        SHIFT_S,
        PAD_S
    } state_e;

    state_e state_q, state_d;

    logic [1:0] sclk_sync_q, lrck_sync_q, sdin_sync_q;
    logic       sclk_prev_q;
    logic       lrck_q, lrck_d;
    logic       sclk_s, lrck_s, sdin_s;
    logic       rise, fall, lrck_edge, left_edge;

    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]        rx_shift_q, rx_shift_d;
    logic                 rx_done_q, rx_done_d;
    logic [DataWidth-1:0] rx_data_q, rx_data_d;
    logic                 rx_chan_q, rx_chan_d;
    logic                 rx_valid_q;
    logic                 frame_err_q, frame_err_d;

    logic [DataWidth-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic [DataWidth-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic [DataWidth-1:0] tx_sample;
    logic [SW-1:0]        tx_word;
    logic [SW-1:0]        tx_shift_q, tx_shift_d;
    logic                 sdout_q, sdout_d;
    logic                 tx_taken_q;

    assign sclk_s = sclk_sync_q[1];
    assign lrck_s = lrck_sync_q[1];
    assign sdin_s = sdin_sync_q[1];

    assign rise      = sclk_s & ~sclk_prev_q;
    assign fall      = ~sclk_s & sclk_prev_q;
    assign lrck_edge = fall & (lrck_s != lrck_q);
    assign left_edge = lrck_edge & ~lrck_s;
    assign lrck_d    = fall ? lrck_s : lrck_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        if (lrck_edge) begin
            bit_cnt_d = '0;
        end else if (rise && (state_q == SHIFT_S || state_q == PAD_S)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
        unique case (state_q)
            SYNC_S: begin
                if (lrck_edge) state_d = DELAY_S;
            end
            DELAY_S: begin
                if (lrck_edge) begin
                    frame_err_d = 1'b1;
                end else if (rise) begin
                    state_d = SHIFT_S;
                end
            end
            SHIFT_S: begin
                if (lrck_edge) begin
                    state_d     = DELAY_S;
                    frame_err_d = 1'b1;
                end else if (rise) begin
                    rx_shift_d = {rx_shift_q[SW-2:0], sdin_s};
                    if (bit_cnt_q == CntW'(SW - 1)) begin
                        state_d   = PAD_S;
                        rx_done_d = 1'b1;
                    end
                end
            end
            PAD_S: begin
                if (lrck_edge) state_d = DELAY_S;
            end
            default: state_d = SYNC_S;
        endcase
    end

    // Word is published one clk after the last capture, from the settled shifter.
    always_comb begin
        rx_data_d = rx_data_q;
        rx_chan_d = rx_chan_q;
        if (rx_done_q) begin
            rx_data_d = rx_shift_q[SW-1 -: DataWidth];
            rx_chan_d = lrck_q;
        end
    end

    // A txValid coinciding with the left edge wins over the older pending pair.
    always_comb begin
        pend_l_d  = bus.txValid ? bus.txLeft  : pend_l_q;
        pend_r_d  = bus.txValid ? bus.txRight : pend_r_q;
        frame_l_d = left_edge ? pend_l_d : frame_l_q;
        frame_r_d = left_edge ? pend_r_d : frame_r_q;
        tx_sample = lrck_s ? frame_r_d : frame_l_d;
        tx_word   = '0;
        tx_word[SW-1 -: DataWidth] = tx_sample;
        tx_shift_d = tx_shift_q;
        sdout_d    = sdout_q;
        if (lrck_edge) begin
            tx_shift_d = tx_word;
            sdout_d    = 1'b0;
        end else if (fall && state_q != SYNC_S) begin
            tx_shift_d = {tx_shift_q[SW-2:0], 1'b0};
            sdout_d    = tx_shift_q[SW-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            lrck_sync_q <= '0;
            sdin_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            lrck_q      <= 1'b0;
            state_q     <= SYNC_S;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_done_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_chan_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            pend_l_q    <= '0;
            pend_r_q    <= '0;
            frame_l_q   <= '0;
            frame_r_q   <= '0;
            tx_shift_q  <= '0;
            sdout_q     <= 1'b0;
            tx_taken_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], bus.sclk};
            lrck_sync_q <= {lrck_sync_q[0], bus.lrck};
            sdin_sync_q <= {sdin_sync_q[0], bus.sdin};
            sclk_prev_q <= sclk_s;
            lrck_q      <= lrck_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_done_q   <= rx_done_d;
            rx_data_q   <= rx_data_d;
            rx_chan_q   <= rx_chan_d;
            rx_valid_q  <= rx_done_q;
            frame_err_q <= frame_err_d;
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            frame_l_q   <= frame_l_d;
            frame_r_q   <= frame_r_d;
            tx_shift_q  <= tx_shift_d;
            sdout_q     <= sdout_d;
            tx_taken_q  <= left_edge;
        end
    end

    assign bus.sdout      = sdout_q;
    assign bus.rxData     = rx_data_q;
    assign bus.rxChannel  = rx_chan_q;
    assign bus.rxValid    = rx_valid_q;
    assign bus.frameError = frame_err_q;
    assign bus.txTaken    = tx_taken_q;
endmodule
